// File: rtl/division_result_display.sv
// Captures divider results, converts the selected value to BCD with a sequential
// double-dabble and scans it onto a 4-digit multiplexed seven-segment display.
module division_result_display #(
  parameter logic [15:0] SCAN_DIV         = 16'd50000,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic [15:0] quotient,
  input  logic [16:0] remainder,
  input  logic        sel,
  output logic [6:0]  seg,
  output logic [3:0]  digit,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [6:0] PAT_BLANK = 7'h00;
  localparam logic [6:0] PAT_DASH  = 7'h40;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = PAT_BLANK;
    endcase
    return p;
  endfunction

  state_t      state_reg;
  logic        done_d_reg;
  logic        sel_d_reg;
  logic [15:0] hold_q_reg;
  logic [16:0] hold_r_reg;
  logic        pending_reg;
  logic [3:0]  count_reg;
  logic [15:0] bin_reg;
  logic [19:0] bcd_reg;
  logic        neg_reg;
  logic [15:0] disp_reg;
  logic        ovf_reg;
  logic [15:0] scan_cnt_reg;
  logic [1:0]  scan_idx_reg;
  logic [6:0]  seg_reg;
  logic [3:0]  digit_reg;

  logic        capture;
  logic        trigger;
  logic [15:0] src_q;
  logic [16:0] src_r;
  logic [15:0] load_bin;
  logic        load_neg;
  logic [19:0] bcd_adj;
  logic [19:0] bcd_next;
  logic        last_shift;
  logic [6:0]  pat [4];
  logic [3:0]  blank;

  assign capture    = done & ~done_d_reg;
  assign trigger    = capture | (sel != sel_d_reg);
  // A capture on this very edge must feed the load, before the holding registers catch up.
  assign src_q      = capture ? quotient  : hold_q_reg;
  assign src_r      = capture ? remainder : hold_r_reg;
  assign load_bin   = sel ? src_r[15:0] : src_q;
  assign load_neg   = sel & src_r[16];
  assign last_shift = (count_reg == 4'd15);

  for (genvar gi = 0; gi < 5; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                               : bcd_reg[4*gi +: 4];
  end
  assign bcd_next = 20'({bcd_adj, bin_reg[15]});

  // Blank every digit above the most significant nonzero one; units always shows.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign blank[gi] = (gi != 0) && (disp_reg[15:4*gi] == '0);
    assign pat[gi]   = ovf_reg   ? PAT_DASH  :
                       blank[gi] ? PAT_BLANK : seg7(disp_reg[4*gi +: 4]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      done_d_reg   <= 1'b0;
      sel_d_reg    <= 1'b0;
      hold_q_reg   <= '0;
      hold_r_reg   <= '0;
      pending_reg  <= 1'b0;
      count_reg    <= '0;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      neg_reg      <= 1'b0;
      disp_reg     <= '0;
      ovf_reg      <= 1'b0;
      scan_cnt_reg <= '0;
      scan_idx_reg <= '0;
      seg_reg      <= {7{SEG_ACTIVE_LOW}};
      digit_reg    <= {4{DIGIT_ACTIVE_LOW}};
    end else begin
      done_d_reg <= done;
      sel_d_reg  <= sel;
      if (capture) begin
        hold_q_reg <= quotient;
        hold_r_reg <= remainder;
      end

      case (state_reg)
        IDLE: begin
          if (trigger) begin
            state_reg <= CONV;
            bin_reg   <= load_bin;
            bcd_reg   <= '0;
            count_reg <= '0;
            neg_reg   <= load_neg;
          end
        end
        CONV: begin
          bin_reg   <= bin_reg << 1;
          bcd_reg   <= bcd_next;
          count_reg <= count_reg + 4'd1;
          if (trigger) begin
            pending_reg <= 1'b1;
          end
          if (last_shift) begin
            disp_reg    <= bcd_next[15:0];
            ovf_reg     <= (bcd_next[19:16] != 4'd0) | neg_reg;
            pending_reg <= 1'b0;
            if (pending_reg || trigger) begin
              bin_reg   <= load_bin;
              bcd_reg   <= '0;
              count_reg <= '0;
              neg_reg   <= load_neg;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (scan_cnt_reg == SCAN_DIV - 16'd1) begin
        scan_cnt_reg <= '0;
        scan_idx_reg <= scan_idx_reg + 2'd1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 16'd1;
      end

      seg_reg   <= pat[scan_idx_reg] ^ {7{SEG_ACTIVE_LOW}};
      digit_reg <= (4'b0001 << scan_idx_reg) ^ {4{DIGIT_ACTIVE_LOW}};
    end
  end

  assign seg   = seg_reg;
  assign digit = digit_reg;
  assign busy  = (state_reg == CONV);
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_division_result_display.sv
// Directed bench for division_result_display with SCAN_DIV=4 and active-low outputs.
module tb_division_result_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        done = 1'b0;
  logic [15:0] quotient = '0;
  logic [16:0] remainder = '0;
  logic        sel = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  digit;
  logic        busy;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  logic [6:0] obs [4];

  localparam logic [6:0] S_OFF  = 7'h7F;
  localparam logic [6:0] S_0    = 7'b1000000;
  localparam logic [6:0] S_1    = 7'b1111001;
  localparam logic [6:0] S_3    = 7'b0110000;
  localparam logic [6:0] S_4    = 7'b0011001;
  localparam logic [6:0] S_5    = 7'b0010010;
  localparam logic [6:0] S_6    = 7'b0000010;
  localparam logic [6:0] S_9    = 7'b0010000;
  localparam logic [6:0] S_DASH = 7'b0111111;

  division_result_display #(
    .SCAN_DIV(16'd4),
    .SEG_ACTIVE_LOW(1'b1),
    .DIGIT_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .sel(sel),
    .seg(seg),
    .digit(digit),
    .busy(busy),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs;
    for (int k = 0; k < 4; k++) obs[k] = 'x;
  endtask

  task automatic snap;
    case (digit)
      4'b1110: obs[0] = seg;
      4'b1101: obs[1] = seg;
      4'b1011: obs[2] = seg;
      4'b0111: obs[3] = seg;
      default: ;
    endcase
  endtask

  task automatic observe(input int n);
    clear_obs();
    for (int k = 0; k < n; k++) begin
      tick();
      snap();
    end
  endtask

  task automatic check_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
    check({tag, "_d3"}, obs[3], e3);
    check({tag, "_d2"}, obs[2], e2);
    check({tag, "_d1"}, obs[1], e1);
    check({tag, "_d0"}, obs[0], e0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic pulse_done(input logic [15:0] q, input logic [16:0] r);
    quotient  = q;
    remainder = r;
    done      = 1'b1;
    tick();
    done      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] exp_digit;
    logic [6:0] exp_seg;

    // Reset state and scan sequence
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    tick();
    check("rst_seg", seg, 7'h7F);
    check("rst_digit", digit, 4'hF);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_digit = ~(4'b0001 << (i / 4));
      exp_seg   = (i < 4) ? S_0 : S_OFF;
      check($sformatf("scan_digit_%0d", i), digit, exp_digit);
      check($sformatf("scan_seg_%0d", i), seg, exp_seg);
    end

    // Small quotient
    sel = 1'b0;
    pulse_done(16'd1, 17'd0);
    count_busy(n);
    check("q1_busy_cycles", n, 16);
    observe(16);
    check_display("q1", S_OFF, S_OFF, S_OFF, S_1);
    check("q1_ovf", ovf, 1'b0);

    // Multi-digit quotient, then show remainder
    pulse_done(16'd459, 17'd6);
    count_busy(n);
    check("q459_busy_cycles", n, 16);
    observe(16);
    check_display("q459", S_OFF, S_4, S_5, S_9);
    sel = 1'b1;
    tick();
    count_busy(n);
    check("r6_busy_cycles", n, 16);
    observe(16);
    check_display("r6", S_OFF, S_OFF, S_OFF, S_6);
    check("r6_ovf", ovf, 1'b0);

    // Overflow cases
    sel = 1'b0;
    pulse_done(16'd65535, 17'd0);
    count_busy(n);
    observe(16);
    check("q65535_ovf", ovf, 1'b1);
    check_display("q65535", S_DASH, S_DASH, S_DASH, S_DASH);
    sel = 1'b1;
    pulse_done(16'd0, 17'h10000);
    count_busy(n);
    observe(16);
    check("rneg_ovf", ovf, 1'b1);
    check_display("rneg", S_DASH, S_DASH, S_DASH, S_DASH);
    sel = 1'b0;
    pulse_done(16'd9999, 17'd0);
    count_busy(n);
    observe(16);
    check("q9999_ovf", ovf, 1'b0);
    check_display("q9999", S_9, S_9, S_9, S_9);

    // Second capture during a conversion
    pulse_done(16'd1459, 17'd0);
    n = 0;
    clear_obs();
    for (int i = 0; i < 49; i++) begin
      if (busy === 1'b1) n++;
      if (i == 4) begin
        quotient = 16'd3;
        done     = 1'b1;
      end
      if (i == 5) done = 1'b0;
      if (i >= 17) snap();
      if (i == 32) begin
        check_display("q1459", S_1, S_4, S_5, S_9);
        check("q1459_busy_end", busy, 1'b0);
        clear_obs();
      end
      tick();
    end
    check("b2b_busy_cycles", n, 32);
    check_display("q3", S_OFF, S_OFF, S_OFF, S_3);

    // Reset during a conversion
    pulse_done(16'd2017, 17'd0);
    for (int i = 0; i < 7; i++) tick();
    #3 rst = 1'b0;
    #1;
    check("midrst_seg", seg, 7'h7F);
    check("midrst_digit", digit, 4'hF);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    observe(16);
    check_display("after_rst", S_OFF, S_OFF, S_OFF, S_0);
    check("after_rst_busy", busy, 1'b0);
    check("after_rst_ovf", ovf, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
